ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester arbiter that shares the single data RAM (write port plus read port, 1-cycle synchronous read) between requesters.
- Master 0 is the CPU load/store unit. Master 1 is the loader/debug port that preloads and inspects memory.
- Grants at most one access per cycle using round-robin priority, with an optional bounded lock for back-to-back bursts.
- Drives the RAM's wen/ren/address/data inputs and routes the read data back to the master that issued the read.

Parameters:
- AW, 32, requester and RAM address width (the RAM itself decodes only the low bits).
- DW, 32, data width.
- MAX_LOCK, 4, maximum consecutive grants one locked master may hold (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 access request; held with its fields until granted.
- m0_we  in  1  1 = write, 0 = read.
- m0_lock  in  1  request to keep the grant on the next cycle.
- m0_addr  in  AW  address.
- m0_wdata  in  DW  write data.
- m0_gnt  out  1  access accepted this cycle.
- m0_rvalid  out  1  read data valid.
- m0_rdata  out  DW  read data.
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the m0_* ports, for master 1.
- ram_wen  out  1  RAM write enable.
- ram_w_addr  out  AW  RAM write address.
- ram_w_data  out  DW  RAM write data.
- ram_ren  out  1  RAM read enable.
- ram_r_addr  out  AW  RAM read address.
- ram_r_data  in  DW  RAM read data, valid 1 cycle after ram_ren.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- On reset:
  - All gnt, rvalid, ram_wen and ram_ren are 0; rdata and RAM address/data outputs are 0.
  - Priority pointer selects m0; lock owner cleared; lock counter 0; pending-read flag cleared.
- Arbitration is combinational within the cycle:
  - If a lock is active and the owner still has req=1, the owner wins.
  - Otherwise, if only one req is high, that master wins.
  - If both are high, the master indicated by the priority pointer wins.
- gnt is a single-cycle pulse to the winner in the same cycle as its req. The loser sees gnt=0 and must hold its req and fields.
- Winner is a write: ram_wen=1, ram_w_addr=addr, ram_w_data=wdata in the same cycle; ram_ren=0.
- Winner is a read: ram_ren=1, ram_r_addr=addr in the same cycle; ram_wen=0.
- When nothing is granted, ram_wen=0 and ram_ren=0. Addresses and data are don't-care but must equal the m0 fields, so there is no X propagation.
- Read return:
  - Registers rd_pend and rd_owner on a read grant.
  - Next cycle: <owner>_rvalid=1 for exactly one cycle and <owner>_rdata=ram_r_data. The other master's rdata holds its previous value.
  - Read-to-rvalid latency is exactly 1 cycle.
  - Back-to-back reads (one per cycle, either master) give back-to-back rvalids in order.
- Pointer update, on every grant that is not lock-continued: pointer moves to the non-winning master.
- Lock:
  - Grant with lock=1: the owner becomes the winner and the counter increments.
  - The lock releases when:
    - the owner's lock=0 on a grant,
    - the owner's req=0 in a cycle, or
    - the counter reaches MAX_LOCK. The MAX_LOCK-th consecutive grant is the last; then the pointer moves to the other master and the counter clears.
  - Lock with no competing req behaves the same (the counter still runs).
- Simultaneous read by one master and write by the other: impossible, since only one grant per cycle. A write granted in the cycle after a read to the same address does not affect the returned data (the read was sampled at grant).
- Reset during a pending read: rvalid is not produced and the pending flag is cleared.
- Arbitration never grants a master whose req=0.

Test Plan:
- Reset, then m0 write addr 0x10 data 0xDEADBEEF alone -> m0_gnt=1, ram_wen=1, ram_w_addr=0x10 same cycle; m1 outputs stay 0.
- m0 read 0x10 after the write -> ram_ren in the grant cycle; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF; m1_rvalid=0.
- Both masters request continuously, no lock, from reset -> grants alternate m0, m1, m0, m1; each read's rvalid goes to the correct master 1 cycle later.
- m1 lock=1 with 6 reads while m0 also requests, MAX_LOCK=4 -> m1 granted 4 consecutive cycles, then m0 granted, then m1 resumes.
- m0 lock=1 then drops req after 2 grants while m1 requests -> m1 granted in the next cycle; counter cleared.
- m1 read granted, rst=1 in the next cycle -> m1_rvalid stays 0, all outputs return to reset values, pointer back to m0.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bundle for the shared data RAM.
// Carries the two requester ports (m0 = CPU load/store unit, m1 = loader/debug
// port) and the RAM write/read port. The arbiter uses the slave view. The
// requesters together with the RAM use the master view.
interface ram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  // Master 0: CPU load/store unit
  logic          m0_req;
  logic          m0_we;
  logic          m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  // Master 1: loader / debug port
  logic          m1_req;
  logic          m1_we;
  logic          m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  // RAM port: write side plus a read side with a 1-cycle synchronous read
  logic          ram_wen;
  logic [AW-1:0] ram_w_addr;
  logic [DW-1:0] ram_w_data;
  logic          ram_ren;
  logic [AW-1:0] ram_r_addr;
  logic [DW-1:0] ram_r_data;

  // Arbiter view
  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output ram_wen, ram_w_addr, ram_w_data, ram_ren, ram_r_addr,
    input  ram_r_data
  );

  // Requester and RAM view
  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  ram_wen, ram_w_addr, ram_w_data, ram_ren, ram_r_addr,
    output ram_r_data
  );

endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of the single data RAM.
// It grants at most one access per cycle. Priority is round-robin, and a
// winner can hold a bounded lock for back-to-back bursts. The grant and the
// RAM command are issued in the same cycle as the request. Read data returns
// to the issuing master exactly one cycle after its read grant.
module ram_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 4
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  // The lock counter is 4 bits wide, so MAX_LOCK is limited to 1..15.
  localparam logic [3:0] MAX_LOCK_C = 4'(MAX_LOCK);

  // Arbitration state
  logic          ptr_r;         // round-robin pointer: 0 = m0 preferred, 1 = m1
  logic          lock_act_r;    // a lock is currently held
  logic          lock_own_r;    // master holding the lock
  logic [3:0]    lock_cnt_r;    // consecutive grants taken under the lock

  // Read return state
  logic          rd_pend_r;     // a read was granted last cycle
  logic          rd_own_r;      // master that issued that read
  logic [DW-1:0] m0_rdata_r;    // last data returned to m0
  logic [DW-1:0] m1_rdata_r;    // last data returned to m1

  // Combinational arbitration results
  logic          req0_s;
  logic          req1_s;
  logic          own_req_s;
  logic          lock_hold_s;
  logic          any_gnt_s;
  logic          win_s;
  logic          win_we_s;
  logic          win_lock_s;
  logic [AW-1:0] win_addr_s;
  logic [DW-1:0] win_wdata_s;
  logic [3:0]    cnt_next_s;
  logic          rvalid0_s;
  logic          rvalid1_s;

  // Mask the requests during reset, so that no grant escapes in a reset cycle.
  always_comb begin
    req0_s = bus.m0_req & ~rst;
    req1_s = bus.m1_req & ~rst;
  end

  // Choose the winner: a held lock first, then a lone requester, then the pointer.
  always_comb begin
    lock_hold_s = 1'b0;
    any_gnt_s   = 1'b0;
    win_s       = 1'b0;
    own_req_s   = lock_own_r ? req1_s : req0_s;
    if (lock_act_r && own_req_s) begin
      lock_hold_s = 1'b1;
      any_gnt_s   = 1'b1;
      win_s       = lock_own_r;
    end else if (req0_s && req1_s) begin
      any_gnt_s   = 1'b1;
      win_s       = ptr_r;
    end else if (req0_s) begin
      any_gnt_s   = 1'b1;
      win_s       = 1'b0;
    end else if (req1_s) begin
      any_gnt_s   = 1'b1;
      win_s       = 1'b1;
    end else begin
      any_gnt_s   = 1'b0;
      win_s       = 1'b0;
    end
  end

  // Select the winner's fields. With no grant, win_s is 0, so the m0 fields pass through.
  always_comb begin
    win_we_s    = 1'b0;
    win_lock_s  = 1'b0;
    win_addr_s  = '0;
    win_wdata_s = '0;
    if (win_s) begin
      win_we_s    = bus.m1_we;
      win_lock_s  = bus.m1_lock;
      win_addr_s  = bus.m1_addr;
      win_wdata_s = bus.m1_wdata;
    end else begin
      win_we_s    = bus.m0_we;
      win_lock_s  = bus.m0_lock;
      win_addr_s  = bus.m0_addr;
      win_wdata_s = bus.m0_wdata;
    end
  end

  // Count this grant. The count continues only when the grant extends the held lock.
  always_comb begin
    if (lock_hold_s) begin
      cnt_next_s = lock_cnt_r + 4'd1;
    end else begin
      cnt_next_s = 4'd1;
    end
  end

  // Drive the grant pulses and the RAM command for the current cycle.
  always_comb begin
    bus.m0_gnt     = any_gnt_s & ~win_s;
    bus.m1_gnt     = any_gnt_s &  win_s;
    bus.ram_wen    = any_gnt_s &  win_we_s;
    bus.ram_ren    = any_gnt_s & ~win_we_s;
    if (rst) begin
      bus.ram_w_addr = '0;
      bus.ram_w_data = '0;
      bus.ram_r_addr = '0;
    end else begin
      bus.ram_w_addr = win_addr_s;
      bus.ram_w_data = win_wdata_s;
      bus.ram_r_addr = win_addr_s;
    end
  end

  // Update the round-robin pointer and the lock owner and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r      <= 1'b0;
      lock_act_r <= 1'b0;
      lock_own_r <= 1'b0;
      lock_cnt_r <= 4'd0;
    end else if (any_gnt_s) begin
      // During a lock the pointer already points away from the owner, so
      // "point at the loser" is correct for every grant.
      ptr_r <= ~win_s;
      if (win_lock_s && (cnt_next_s < MAX_LOCK_C)) begin
        lock_act_r <= 1'b1;
        lock_own_r <= win_s;
        lock_cnt_r <= cnt_next_s;
      end else begin
        // The lock was not requested, or this was the last grant the lock allows.
        lock_act_r <= 1'b0;
        lock_own_r <= 1'b0;
        lock_cnt_r <= 4'd0;
      end
    end else begin
      // No grant: nobody requests, so any lock is dropped.
      ptr_r      <= ptr_r;
      lock_act_r <= 1'b0;
      lock_own_r <= 1'b0;
      lock_cnt_r <= 4'd0;
    end
  end

  // Track the read in flight and capture the returned data for each master's hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_r  <= 1'b0;
      rd_own_r   <= 1'b0;
      m0_rdata_r <= '0;
      m1_rdata_r <= '0;
    end else begin
      rd_pend_r <= any_gnt_s & ~win_we_s;
      rd_own_r  <= win_s;
      if (rd_pend_r && !rd_own_r) begin
        m0_rdata_r <= bus.ram_r_data;
      end else begin
        m0_rdata_r <= m0_rdata_r;
      end
      if (rd_pend_r && rd_own_r) begin
        m1_rdata_r <= bus.ram_r_data;
      end else begin
        m1_rdata_r <= m1_rdata_r;
      end
    end
  end

  // Steer the RAM read data to the owner of the pending read. A reset in the return cycle suppresses it.
  always_comb begin
    rvalid0_s     = rd_pend_r & ~rd_own_r & ~rst;
    rvalid1_s     = rd_pend_r &  rd_own_r & ~rst;
    bus.m0_rvalid = rvalid0_s;
    bus.m1_rvalid = rvalid1_s;
    if (rvalid0_s) begin
      bus.m0_rdata = bus.ram_r_data;
    end else begin
      bus.m0_rdata = m0_rdata_r;
    end
    if (rvalid1_s) begin
      bus.m1_rdata = bus.ram_r_data;
    end else begin
      bus.m1_rdata = m1_rdata_r;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter.
// The bench provides a behavioural RAM. It keeps its own shadow copy of memory
// and a queue of expected read returns, filled at each read grant.
module tb_ram_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  ram_arbiter_if #(.AW(32), .DW(32)) bus ();

  ram_arbiter #(.AW(32), .DW(32), .MAX_LOCK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        m;
    logic [31:0] d;
  } rd_t;

  rd_t         exp_q [$];
  logic [31:0] shadow [0:255];
  logic [31:0] mem    [0:255];
  logic [31:0] exp_rd0;
  logic [31:0] exp_rd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, and a read with 1-cycle latency.
  always @(posedge clk) begin
    if (bus.ram_wen) mem[bus.ram_w_addr[7:0]] <= bus.ram_w_data;
    if (bus.ram_ren) bus.ram_r_data <= mem[bus.ram_r_addr[7:0]];
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic req, input logic we, input logic lock,
                      input logic [31:0] addr, input logic [31:0] wdata);
    bus.m0_req = req; bus.m0_we = we; bus.m0_lock = lock;
    bus.m0_addr = addr; bus.m0_wdata = wdata;
  endtask

  task automatic drv1(input logic req, input logic we, input logic lock,
                      input logic [31:0] addr, input logic [31:0] wdata);
    bus.m1_req = req; bus.m1_we = we; bus.m1_lock = lock;
    bus.m1_addr = addr; bus.m1_wdata = wdata;
  endtask

  // One clock cycle. The expected grants are given. Outputs are checked at the negedge.
  task automatic step(input logic eg0, input logic eg1);
    logic ev0;
    logic ev1;
    rd_t  e;
    @(negedge clk);
    ev0 = 1'b0;
    ev1 = 1'b0;
    if (rst) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.m) begin ev1 = 1'b1; exp_rd1 = e.d; end
      else     begin ev0 = 1'b1; exp_rd0 = e.d; end
    end
    chk1("m0_rvalid", bus.m0_rvalid, ev0);
    chk1("m1_rvalid", bus.m1_rvalid, ev1);
    if (!rst) begin
      chk32("m0_rdata", bus.m0_rdata, exp_rd0);
      chk32("m1_rdata", bus.m1_rdata, exp_rd1);
    end
    chk1("m0_gnt", bus.m0_gnt, eg0);
    chk1("m1_gnt", bus.m1_gnt, eg1);
    chk1("ram_wen", bus.ram_wen, (eg0 & bus.m0_we) | (eg1 & bus.m1_we));
    chk1("ram_ren", bus.ram_ren, (eg0 & ~bus.m0_we) | (eg1 & ~bus.m1_we));
    if (eg0) begin
      if (bus.m0_we) begin
        chk32("m0_w_addr", bus.ram_w_addr, bus.m0_addr);
        chk32("m0_w_data", bus.ram_w_data, bus.m0_wdata);
        shadow[bus.m0_addr[7:0]] = bus.m0_wdata;
      end else begin
        chk32("m0_r_addr", bus.ram_r_addr, bus.m0_addr);
        exp_q.push_back('{m: 1'b0, d: shadow[bus.m0_addr[7:0]]});
      end
    end
    if (eg1) begin
      if (bus.m1_we) begin
        chk32("m1_w_addr", bus.ram_w_addr, bus.m1_addr);
        chk32("m1_w_data", bus.ram_w_data, bus.m1_wdata);
        shadow[bus.m1_addr[7:0]] = bus.m1_wdata;
      end else begin
        chk32("m1_r_addr", bus.ram_r_addr, bus.m1_addr);
        exp_q.push_back('{m: 1'b1, d: shadow[bus.m1_addr[7:0]]});
      end
    end
    if (rst) begin
      exp_rd0 = 32'h0;
      exp_rd1 = 32'h0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    exp_rd0 = 32'h0;
    exp_rd1 = 32'h0;
    rst     = 1'b1;
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0);
    chk32("idle_w_addr", bus.ram_w_addr, 32'h0);
    chk32("idle_w_data", bus.ram_w_data, 32'h0);
    chk32("idle_r_addr", bus.ram_r_addr, 32'h0);

    // m0 writes alone, then reads the same address back
    drv0(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF); step(1'b1, 1'b0);
    drv0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);        step(1'b1, 1'b0);
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);         step(1'b0, 1'b0);

    // Both masters request continuously after reset: grants alternate starting with m0
    rst = 1'b1; step(1'b0, 1'b0); rst = 1'b0;
    drv0(1'b1, 1'b1, 1'b0, 32'h20, 32'hA1); drv1(1'b1, 1'b1, 1'b0, 32'h30, 32'hB1); step(1'b1, 1'b0);
    drv0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);  step(1'b0, 1'b1);
    drv1(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);  step(1'b1, 1'b0);
    drv0(1'b1, 1'b0, 1'b0, 32'h30, 32'h0);  step(1'b0, 1'b1);
    drv1(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);  step(1'b1, 1'b0);
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);   step(1'b0, 1'b1);
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);   step(1'b0, 1'b0);

    // m1 locked burst of 6 reads against a waiting m0 (pointer set to m1 first)
    drv0(1'b1, 1'b1, 1'b0, 32'h40, 32'hC1); step(1'b1, 1'b0);
    drv0(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    drv1(1'b1, 1'b0, 1'b1, 32'h10, 32'h0);  step(1'b0, 1'b1);
    drv1(1'b1, 1'b0, 1'b1, 32'h20, 32'h0);  step(1'b0, 1'b1);
    drv1(1'b1, 1'b0, 1'b1, 32'h30, 32'h0);  step(1'b0, 1'b1);
    drv1(1'b1, 1'b0, 1'b1, 32'h40, 32'h0);  step(1'b0, 1'b1);
    drv1(1'b1, 1'b0, 1'b1, 32'h10, 32'h0);  step(1'b1, 1'b0);
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);   step(1'b0, 1'b1);
    drv1(1'b1, 1'b0, 1'b1, 32'h20, 32'h0);  step(1'b0, 1'b1);
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);   step(1'b0, 1'b0);

    // m0 locks, drops req after 2 grants; then a fresh full-length lock shows the counter restarted
    drv0(1'b1, 1'b1, 1'b1, 32'h50, 32'hE1); drv1(1'b1, 1'b0, 1'b0, 32'h50, 32'h0); step(1'b1, 1'b0);
    drv0(1'b1, 1'b1, 1'b1, 32'h54, 32'hE2); step(1'b1, 1'b0);
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);   step(1'b0, 1'b1);
    drv0(1'b1, 1'b0, 1'b1, 32'h54, 32'h0);  drv1(1'b1, 1'b0, 1'b0, 32'h54, 32'h0);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);   step(1'b1, 1'b0);
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);   step(1'b0, 1'b0);

    // Reset while an m1 read is pending: no rvalid, and the pointer returns to m0
    drv1(1'b1, 1'b0, 1'b0, 32'h50, 32'h0);  step(1'b0, 1'b1);
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);   rst = 1'b1; step(1'b0, 1'b0);
    rst = 1'b0;                             step(1'b0, 1'b0);
    drv0(1'b1, 1'b1, 1'b0, 32'h60, 32'hF0); drv1(1'b1, 1'b1, 1'b0, 32'h64, 32'hF1); step(1'b1, 1'b0);
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);   step(1'b0, 1'b1);
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);   step(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
